// File: rtl/ls_sched_pkg.sv
// ============================================================================
//  Module      : ls_sched_pkg
//  Description : Shared types and constants for the landscape-sampling
//                request scheduler (FSM state encoding, channel indices,
//                counter-width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ls_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Channel indices into the {z, y, x} vectors
  localparam int CH_X = 0;
  localparam int CH_Y = 1;
  localparam int CH_Z = 2;
  localparam int N_CH = 3;

  // Width of the shared pulse/gap down-counter: must hold max(pw, gap)
  function automatic int cnt_width(input int pw, input int gap);
    int m;
    m = (pw > gap) ? pw : gap;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ls_pend_slot.sv
// ============================================================================
//  Module      : ls_pend_slot
//  Description : One channel slot of the request scheduler. Detects rising
//                edges on the raw event input, holds at most one pending
//                event, ages it, and pulses drop for a coalesced or an
//                aged-out event.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ls_pend_slot #(
  parameter int age_max = 255,
  parameter int bit_age = $clog2(age_max + 1)
) (
  input  logic clk_main,
  input  logic rst_n,
  input  logic raw,
  input  logic grant,
  output logic pend,
  output logic drop
);

  localparam logic [bit_age-1:0] AGE_LIM = bit_age'(age_max);

  logic               r_prev;
  logic               r_pend;
  logic               r_drop;
  logic [bit_age-1:0] r_age;

  logic w_edge;
  logic w_expire;
  logic w_coalesce;

  // A rising edge is a new event; the previous level resets low so a raw
  // input already high out of reset counts as one event.
  assign w_edge = raw & ~r_prev;

  // Age expiry only applies to an event that is not being served this cycle.
  assign w_expire = r_pend & ~grant & (r_age == AGE_LIM);

  // A second event on an occupied, unserved slot is merged into the first.
  // At expiry the new edge instead refills the slot, so only one drop.
  assign w_coalesce = w_edge & r_pend & ~grant & ~w_expire;

  // Pending flag, age counter and drop pulse update
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
      r_drop <= 1'b0;
      r_age  <= '0;
    end else begin
      r_prev <= raw;
      r_drop <= w_coalesce | w_expire;
      if (w_edge) begin
        r_pend <= 1'b1;
        if (w_coalesce) begin
          // Slot keeps the original event and keeps aging it
          r_age <= r_age + 1'b1;
        end else begin
          // Fresh event: slot was empty, granted, or just expired
          r_age <= '0;
        end
      end else if (grant || w_expire) begin
        r_pend <= 1'b0;
        r_age  <= '0;
      end else if (r_pend) begin
        r_age <= r_age + 1'b1;
      end
    end
  end

  assign pend = r_pend;
  assign drop = r_drop;

endmodule

`default_nettype wire

// File: rtl/ls_req_sched.sv
// ============================================================================
//  Module      : ls_req_sched
//  Description : Request scheduler for the landscape-sampling datapath.
//                Collects x/y/z spike events in single-entry slots and
//                issues them one at a time as fixed-width request pulses
//                separated by a minimum idle gap. z is held off while the
//                datapath is rewriting its output memory (busy).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ls_req_sched
  import ls_sched_pkg::*;
#(
  parameter int pw      = 4,
  parameter int gap     = 2,
  parameter int age_max = 255,
  parameter int bit_age = $clog2(age_max + 1)
) (
  input  logic       clk_main,
  input  logic       rst_n,
  input  logic       raw_x,
  input  logic       raw_y,
  input  logic       raw_z,
  input  logic       busy,
  output logic       request_x,
  output logic       request_y,
  output logic       request_z,
  output logic       drop_x,
  output logic       drop_y,
  output logic       drop_z,
  output logic [2:0] pend
);

  localparam int bit_cnt = cnt_width(pw, gap);

  // Counter reload values; the counter counts down to zero inclusive
  localparam logic [bit_cnt-1:0] CNT_PW  = bit_cnt'(pw - 1);
  localparam logic [bit_cnt-1:0] CNT_GAP = bit_cnt'(gap - 1);

  state_t             r_state;
  logic [bit_cnt-1:0] r_cnt;
  logic [N_CH-1:0]    r_req;
  logic               r_last_y;   // 1: y was the last x/y channel served

  logic [N_CH-1:0] w_raw;
  logic [N_CH-1:0] w_pend;
  logic [N_CH-1:0] w_drop;
  logic [N_CH-1:0] w_grant;
  logic            w_any;

  assign w_raw = {raw_z, raw_y, raw_x};

  // One pending slot per channel
  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    ls_pend_slot #(
      .age_max (age_max),
      .bit_age (bit_age)
    ) u_slot (
      .clk_main (clk_main),
      .rst_n    (rst_n),
      .raw      (w_raw[i]),
      .grant    (w_grant[i]),
      .pend     (w_pend[i]),
      .drop     (w_drop[i])
    );
  end

  // Arbiter: grants only in IDLE; z first when the datapath is not busy,
  // then x/y with the tie going to whichever was not served last.
  always_comb begin
    w_grant = '0;
    if (r_state == IDLE) begin
      if (w_pend[CH_Z] && !busy) begin
        w_grant[CH_Z] = 1'b1;
      end else if (w_pend[CH_X] && w_pend[CH_Y]) begin
        if (r_last_y) begin
          w_grant[CH_X] = 1'b1;
        end else begin
          w_grant[CH_Y] = 1'b1;
        end
      end else if (w_pend[CH_X]) begin
        w_grant[CH_X] = 1'b1;
      end else if (w_pend[CH_Y]) begin
        w_grant[CH_Y] = 1'b1;
      end
    end
  end

  assign w_any = |w_grant;

  // Pulse/gap sequencer with registered request outputs. The pulse always
  // runs its full width once started; busy only affects new grants.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_req    <= '0;
      r_last_y <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_req   <= w_grant;
            r_cnt   <= CNT_PW;
            r_state <= PULSE;
            if (w_grant[CH_X]) begin
              r_last_y <= 1'b0;
            end else if (w_grant[CH_Y]) begin
              r_last_y <= 1'b1;
            end
          end
        end
        PULSE: begin
          if (r_cnt == '0) begin
            r_req <= '0;
            if (gap == 0) begin
              r_state <= IDLE;
            end else begin
              r_cnt   <= CNT_GAP;
              r_state <= GAP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign request_x = r_req[CH_X];
  assign request_y = r_req[CH_Y];
  assign request_z = r_req[CH_Z];

  assign drop_x = w_drop[CH_X];
  assign drop_y = w_drop[CH_Y];
  assign drop_z = w_drop[CH_Z];

  assign pend = w_pend;

endmodule

`default_nettype wire

// File: tb/tb_ls_req_sched.sv
// ============================================================================
//  Module      : tb_ls_req_sched
//  Description : Self-checking bench for ls_req_sched (pw=4, gap=2).
//                u_dut uses age_max=255, u_age uses age_max=10 and shares
//                the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ls_req_sched;

  logic clk_main = 1'b0;
  logic rst_n;
  logic raw_x, raw_y, raw_z, busy;

  logic       request_x, request_y, request_z;
  logic       drop_x, drop_y, drop_z;
  logic [2:0] pend;

  logic       a_request_x, a_request_y, a_request_z;
  logic       a_drop_x, a_drop_y, a_drop_z;
  logic [2:0] a_pend;

  int checks = 0;
  int errors = 0;

  // Per-cycle logs for the hand-written sequences, {z, y, x}
  logic [2:0] rq  [0:39];
  logic [2:0] dp  [0:39];
  logic [2:0] pd  [0:39];
  logic [2:0] arq [0:39];
  logic [2:0] adp [0:39];
  logic [2:0] apd [0:39];

  typedef struct {
    logic       first;   // apply reset before this row
    logic [2:0] raw;     // {z, y, x}
    logic       busy;
    logic [2:0] req;
    logic [2:0] drop;
    logic [2:0] pend;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_main = ~clk_main;

  ls_req_sched #(.pw(4), .gap(2), .age_max(255)) u_dut (
    .clk_main  (clk_main),
    .rst_n     (rst_n),
    .raw_x     (raw_x),
    .raw_y     (raw_y),
    .raw_z     (raw_z),
    .busy      (busy),
    .request_x (request_x),
    .request_y (request_y),
    .request_z (request_z),
    .drop_x    (drop_x),
    .drop_y    (drop_y),
    .drop_z    (drop_z),
    .pend      (pend)
  );

  ls_req_sched #(.pw(4), .gap(2), .age_max(10)) u_age (
    .clk_main  (clk_main),
    .rst_n     (rst_n),
    .raw_x     (raw_x),
    .raw_y     (raw_y),
    .raw_z     (raw_z),
    .busy      (busy),
    .request_x (a_request_x),
    .request_y (a_request_y),
    .request_z (a_request_z),
    .drop_x    (a_drop_x),
    .drop_y    (a_drop_y),
    .drop_z    (a_drop_z),
    .pend      (a_pend)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic first, input logic [2:0] raw, input logic bsy,
                              input logic [2:0] req, input logic [2:0] drp, input logic [2:0] pnd);
    vec_t v;
    v.first = first; v.raw = raw; v.busy = bsy;
    v.req = req; v.drop = drp; v.pend = pnd;
    vecs.push_back(v);
  endfunction

  // Start of a cycle: just after the active edge
  task automatic next_cycle();
    @(posedge clk_main);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    raw_x = 1'b0; raw_y = 1'b0; raw_z = 1'b0; busy = 1'b0;
    repeat (3) @(posedge clk_main);
    @(negedge clk_main);
    check("reset req",  {29'd0, request_z, request_y, request_x}, 32'd0);
    check("reset drop", {29'd0, drop_z, drop_y, drop_x}, 32'd0);
    check("reset pend", {29'd0, pend}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic sample(input int c);
    rq[c]  = {request_z, request_y, request_x};
    dp[c]  = {drop_z, drop_y, drop_x};
    pd[c]  = pend;
    arq[c] = {a_request_z, a_request_y, a_request_x};
    adp[c] = {a_drop_z, a_drop_y, a_drop_x};
    apd[c] = a_pend;
  endtask

  // which: 0 req, 1 drop, 2 age-instance req, 3 age-instance drop
  function automatic logic [2:0] pick(input int which, input int c);
    case (which)
      0:       return rq[c];
      1:       return dp[c];
      2:       return arq[c];
      default: return adp[c];
    endcase
  endfunction

  function automatic int first_high(input int which, input int ch, input int n);
    logic [2:0] v;
    for (int c = 0; c < n; c++) begin
      v = pick(which, c);
      if (v[ch]) return c;
    end
    return -1;
  endfunction

  function automatic int count_high(input int which, input int ch, input int n);
    int k;
    logic [2:0] v;
    k = 0;
    for (int c = 0; c < n; c++) begin
      v = pick(which, c);
      if (v[ch]) k++;
    end
    return k;
  endfunction

  function automatic int count_multi(input int n);
    int k;
    k = 0;
    for (int c = 0; c < n; c++) if ($countones(rq[c]) > 1) k++;
    return k;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    raw_x = 1'b0; raw_y = 1'b0; raw_z = 1'b0; busy = 1'b0;

    // Single x edge: request_x cycles 2..5, pend[0] high only in cycle 1
    add(1, 3'b001, 0, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 0, 3'b000, 3'b000, 3'b001);
    for (int i = 2; i <= 5; i++) add(0, 3'b000, 0, 3'b001, 3'b000, 3'b000);
    for (int i = 6; i <= 9; i++) add(0, 3'b000, 0, 3'b000, 3'b000, 3'b000);

    // x, y, z together: z at 2, x at 9, y at 16
    add(1, 3'b111, 0, 3'b000, 3'b000, 3'b000);
    add(0, 3'b111, 0, 3'b000, 3'b000, 3'b111);
    for (int i = 2;  i <= 5;  i++) add(0, 3'b000, 0, 3'b100, 3'b000, 3'b011);
    for (int i = 6;  i <= 8;  i++) add(0, 3'b000, 0, 3'b000, 3'b000, 3'b011);
    for (int i = 9;  i <= 12; i++) add(0, 3'b000, 0, 3'b001, 3'b000, 3'b010);
    for (int i = 13; i <= 15; i++) add(0, 3'b000, 0, 3'b000, 3'b000, 3'b010);
    for (int i = 16; i <= 19; i++) add(0, 3'b000, 0, 3'b010, 3'b000, 3'b000);
    for (int i = 20; i <= 21; i++) add(0, 3'b000, 0, 3'b000, 3'b000, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].first) do_reset();
      next_cycle();
      {raw_z, raw_y, raw_x} = vecs[i].raw;
      busy = vecs[i].busy;
      @(negedge clk_main);
      check($sformatf("vec%0d req", i),  {29'd0, request_z, request_y, request_x}, {29'd0, vecs[i].req});
      check($sformatf("vec%0d drop", i), {29'd0, drop_z, drop_y, drop_x}, {29'd0, vecs[i].drop});
      check($sformatf("vec%0d pend", i), {29'd0, pend}, {29'd0, vecs[i].pend});
    end

    // z held off by busy (0..19 and again 22..29), x served first
    do_reset();
    for (int c = 0; c < 36; c++) begin
      next_cycle();
      raw_x = (c == 0);
      raw_z = (c == 0);
      busy  = (c < 20) || (c >= 22 && c < 30);
      @(negedge clk_main);
      sample(c);
    end
    check("busy x first rise", first_high(0, 0, 36), 2);
    check("busy x width",      count_high(0, 0, 36), 4);
    check("busy z first rise", first_high(0, 2, 36), 21);
    check("busy z full width", count_high(0, 2, 36), 4);
    check("busy no drop",      count_high(1, 0, 36) + count_high(1, 1, 36) + count_high(1, 2, 36), 0);
    check("busy onehot req",   count_multi(36), 0);

    // Two x edges during a y pulse: one coalesce drop, one x pulse
    do_reset();
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      raw_y = (c == 0);
      raw_x = (c == 2) || (c == 5);
      @(negedge clk_main);
      sample(c);
    end
    check("coal y rise",       first_high(0, 1, 20), 2);
    check("coal drop_x count", count_high(1, 0, 20), 1);
    check("coal drop_x cycle", first_high(1, 0, 20), 6);
    check("coal pend_x kept",  {31'd0, pd[6][0]}, 32'd1);
    check("coal x rise",       first_high(0, 0, 20), 9);
    check("coal x width",      count_high(0, 0, 20), 4);
    check("coal drop_y",       count_high(1, 1, 20), 0);

    // Age expiry with busy stuck high (u_age has age_max=10)
    do_reset();
    for (int c = 0; c < 16; c++) begin
      next_cycle();
      busy  = 1'b1;
      raw_z = (c == 0);
      @(negedge clk_main);
      sample(c);
    end
    check("age pend_z rise",    {31'd0, apd[1][2]}, 32'd1);
    check("age pend_z c11",     {31'd0, apd[11][2]}, 32'd1);
    check("age pend_z cleared", {31'd0, apd[12][2]}, 32'd0);
    check("age drop_z cycle",   first_high(3, 2, 16), 12);
    check("age drop_z count",   count_high(3, 2, 16), 1);
    check("age no request_z",   count_high(2, 2, 16), 0);
    check("age255 pend_z kept", {31'd0, pd[12][2]}, 32'd1);
    check("age255 no drop_z",   count_high(1, 2, 16), 0);

    // Reset in the second cycle of a y pulse, then x with normal latency
    do_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      raw_y = (c == 0);
      raw_x = (c == 2);
      @(negedge clk_main);
    end
    check("rst y in flight", {31'd0, request_y}, 32'd1);
    check("rst x pending",   {29'd0, pend}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst req cut",    {29'd0, request_z, request_y, request_x}, 32'd0);
    check("rst pend lost",  {29'd0, pend}, 32'd0);
    check("rst drop quiet", {29'd0, drop_z, drop_y, drop_x}, 32'd0);
    repeat (2) @(posedge clk_main);
    @(negedge clk_main);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      raw_x = (c == 0);
      raw_y = 1'b0;
      @(negedge clk_main);
      sample(c);
    end
    check("post-rst x rise",  first_high(0, 0, 8), 2);
    check("post-rst no y",    count_high(0, 1, 8), 0);
    check("post-rst no drop", count_high(1, 0, 8) + count_high(1, 1, 8), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
